// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state type and signed-limit helpers for the ALU datapath
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder with carry-out and carry into the MSB
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  logic [CHUNK:0] s;
  assign s = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(cin_i);
  assign sum_o = s[CHUNK-1:0];
  assign cout_o = s[CHUNK];
  // carry into the MSB recovered from the MSB sum bit
  assign cmsb_o = s[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle chunked add/subtract with flags and optional signed saturation
module addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
  state_t state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_d;
  logic [IW-1:0] idx_q;
  logic c_q, ovf_q, amsb_q, op_q, sat_q;
  logic [CHUNK-1:0] s;
  logic co, cm;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i(a_q[CHUNK-1:0]), .b_i(b_q[CHUNK-1:0]), .cin_i(c_q),
    .sum_o(s), .cout_o(co), .cmsb_o(cm)
  );
  always_comb res_d = (sat_q && ovf_q) ? (amsb_q ? SMIN : SMAX) : acc_q;
  // operands shift down one chunk per cycle; the sum fills the accumulator from the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      ovf_q <= 1'b0;
      amsb_q <= 1'b0;
      op_q <= OP_ADD;
      sat_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b ^ {WIDTH{op}};
          c_q <= op;
          op_q <= op;
          sat_q <= sat;
          amsb_q <= a[WIDTH-1];
          idx_q <= '0;
          acc_q <= '0;
          busy <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          c_q <= co;
          acc_q <= WIDTH'({s, acc_q} >> CHUNK);
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            ovf_q <= co ^ cm;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          result <= res_d;
          carry <= c_q ^ op_q;
          overflow <= ovf_q;
          zero <= res_d == '0;
          negative <= res_d[WIDTH-1];
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed vector table plus handshake/reset corner sequences for addsub_seq
module tb_addsub_seq;
  logic clk = 0, rst_n = 0, start = 0, op = 0, sat = 0;
  logic [15:0] a = 0, b = 0, result;
  logic busy, done, carry, overflow, zero, negative;
  int n_cmp = 0, n_bad = 0;
  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sat(sat), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic o, s;
    logic [15:0] x, y, r;
    logic c, v, z, n;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic launch(input logic o, input logic s, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o; sat = s; a = x; b = y; start = 1;
    @(posedge clk);
    #1 start = 0; a = 16'hDEAD; b = 16'hBEEF; op = ~o; sat = ~s;
  endtask
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        return;
      end
    end
  endtask
  task automatic chk_out(input string nm, input logic [15:0] r, input logic c, input logic v, input logic z, input logic n);
    chk({nm, ".res"}, result, r);
    chk({nm, ".carry"}, carry, c);
    chk({nm, ".ovf"}, overflow, v);
    chk({nm, ".zero"}, zero, z);
    chk({nm, ".neg"}, negative, n);
  endtask
  int cyc, cnt;
  logic seen;
  initial begin
    vt[0]  = '{1, 0, 16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 16'h0003, 16'h0005, 16'hFFFE, 1, 0, 0, 1};
    vt[2]  = '{1, 0, 16'h1234, 16'h1234, 16'h0000, 0, 0, 1, 0};
    vt[3]  = '{0, 0, 16'h0FFF, 16'h0001, 16'h1000, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0};
    vt[5]  = '{0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1};
    vt[6]  = '{0, 1, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 1, 0, 0};
    vt[7]  = '{1, 1, 16'h8000, 16'h0001, 16'h8000, 0, 1, 0, 1};
    vt[8]  = '{0, 0, 16'h1234, 16'h4321, 16'h5555, 0, 0, 0, 0};
    vt[9]  = '{0, 1, 16'h8000, 16'h8000, 16'h8000, 1, 1, 0, 1};
    vt[10] = '{1, 0, 16'h0000, 16'h8000, 16'h8000, 1, 1, 0, 1};
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk_out("rst", 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      launch(vt[i].o, vt[i].s, vt[i].x, vt[i].y);
      chk($sformatf("v%0d.busy", i), busy, 1);
      wait_done(cyc);
      chk($sformatf("v%0d.lat", i), cyc, 5);
      chk_out($sformatf("v%0d", i), vt[i].r, vt[i].c, vt[i].v, vt[i].z, vt[i].n);
      chk($sformatf("v%0d.busy_off", i), busy, 0);
    end
    // abort mid-RUN: outputs cleared, no done afterwards
    launch(0, 0, 16'h0001, 16'h0001);
    @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk_out("abort", 16'h0000, 0, 0, 0, 0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("abort.no_done", seen, 0);
    // start pulsed during RUN must be ignored
    launch(0, 0, 16'h0001, 16'h0001);
    @(posedge clk);
    @(negedge clk) begin op = 1; a = 16'hFFFF; b = 16'h0F0F; start = 1; end
    @(posedge clk);
    #1 start = 0;
    wait_done(cyc);
    chk("ign.lat", cyc, 3);
    chk_out("ign", 16'h0002, 0, 0, 0, 0);
    // start held through the done cycle: second op accepted at that edge
    @(negedge clk) begin op = 0; sat = 0; a = 16'h0003; b = 16'h0004; start = 1; end
    @(posedge clk);
    #1 begin op = 1; a = 16'h000A; b = 16'h0005; end
    wait_done(cyc);
    chk("b2b.lat1", cyc, 5);
    chk_out("b2b1", 16'h0007, 0, 0, 0, 0);
    cnt = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        start = 0;
        chk("b2b.busy2", busy, 1);
        chk("b2b.done_once", done, 0);
      end
      if (done) begin
        cnt = i;
        break;
      end
    end
    chk("b2b.gap", cnt, 6);
    chk_out("b2b2", 16'h0005, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle signed/unsigned add/subtract unit: the registered, handshaked successor to the lab's 4-bit combinational subtractor. It processes a WIDTH-bit operation CHUNK bits per clock with a rippled carry, then reports result plus carry/borrow, overflow, zero and negative flags, with optional signed saturation. It sits as an ALU datapath slave of the RISC control FSM, driven by a start/busy/done handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK chunk cycles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- start  input  1  request; accepted only on an edge where busy=0.
- op  input  1  0 = a+b, 1 = a-b; sampled at accept.
- sat  input  1  1 = clamp on signed overflow; sampled at accept.
- a, b  input  WIDTH  operands; sampled at accept, may change afterwards.
- busy  output  1  high from accept until the done edge.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  WIDTH  final (post-saturation) value; held until next done.
- carry  output  1  add: unsigned carry-out; sub: borrow (1 when a<b unsigned).
- overflow  output  1  signed overflow of the unsaturated result.
- zero  output  1  result == 0 (after saturation).
- negative  output  1  result MSB (after saturation).

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: busy=0. start=1 at edge -> latch a, b^{WIDTH{op}}, cin=op, sat, clear chunk index; go RUN.
- RUN: each edge adds chunk k of a and (possibly inverted) b plus rippled carry into the internal accumulator; k increments; after chunk N-1 -> FINISH. start ignored.
- FINISH: flags computed from final carry, operand MSBs and accumulator MSB. overflow = (aMSB == b'MSB) && (sumMSB != aMSB), b' being the inverted operand for sub. carry = cout for add, ~cout for sub.
- Saturation: sat=1 and overflow=1 -> result = 0111..1 if aMSB=0, else 1000..0; overflow still reports 1. sat=0 -> wrapped modulo 2^WIDTH.
- FINISH edge: register result/flags, done=1, busy=0, return IDLE.
- Outputs change only on the done edge or reset.

## Timing
- Reset (rst_n=0 at edge): state IDLE, busy=0, done=0, result=0, carry=0, overflow=0, zero=0, negative=0, accumulator/index cleared. Reset mid-RUN/FINISH aborts silently; no done.
- Latency: accept at edge E0 -> done high after edge E(N+1); N=4 -> 5 cycles.
- Back-to-back: start held high in the done cycle is accepted at that edge; throughput one op per N+2 cycles.
- start while busy=1: no effect, not queued.
- done is never high for two consecutive cycles.
- Carry ripples between chunks through a register only; no combinational path from a/b to outputs.

## Structure
- Shared package alu_pkg: op encodings OP_ADD=0, OP_SUB=1; state enum; helper constants for signed max/min derived from WIDTH.
- One sub-module, addsub_chunk: combinational CHUNK-bit adder (a, b, cin -> sum, cout, plus MSB carry-in for overflow), instantiated once and time-multiplexed over chunks.
- Top holds FSM, chunk index counter, operand shift/select, accumulator, flag and saturation logic.

## Test plan
- WIDTH=16, CHUNK=4: sub 0x0005-0x0003, sat=0 -> done exactly 5 cycles after accept, result 0x0002, carry=0, ovf=0, zero=0, neg=0.
- sub 0x0003-0x0005 -> 0xFFFE, carry(borrow)=1, neg=1, ovf=0; sub 0x1234-0x1234 -> 0x0000, zero=1, carry=0.
- add 0x0FFF+0x0001 -> 0x1000, carry=0 (inter-chunk ripple); add 0xFFFF+0x0001 -> 0x0000, carry=1, zero=1.
- add 0x7FFF+0x0001: sat=0 -> 0x8000, ovf=1, neg=1; sat=1 -> 0x7FFF, ovf=1, neg=0. sub 0x8000-0x0001, sat=1 -> 0x8000, ovf=1.
- start pulsed during RUN with different operands -> ignored, first result unchanged; start held in done cycle -> second op accepted, second done 6 cycles after first.
- rst_n=0 for one edge during RUN -> busy=0, all outputs 0 next cycle, no done pulse; new start afterward completes normally.
